// File: rtl/rv32i_pkg.sv
// rv32i shared types: hazard FSM states, forwarding selects
// and the shadow pipeline bundles tracked by the hazard unit.
package rv32i_pkg;

  localparam int ADW = 5;

  typedef enum logic {
    HZ_RUN,
    HZ_MEM_WAIT
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [ADW-1:0] rs1;
    logic [ADW-1:0] rs2;
    logic [ADW-1:0] rd;
    logic           regwrite;
    logic           load;
    logic           memacc;
  } hz_e_t;

  typedef struct packed {
    logic [ADW-1:0] rd;
    logic           regwrite;
    logic           memacc;
  } hz_m_t;

  typedef struct packed {
    logic [ADW-1:0] rd;
    logic           regwrite;
  } hz_w_t;

endpackage

// File: rtl/forward_unit.sv
// Operand bypass select for one execute source.
// M result wins over W; x0 is never bypassed.
module forward_unit
  import rv32i_pkg::*;
(
  input  logic [ADW-1:0] i_rs,
  input  logic [ADW-1:0] i_rdM,
  input  logic           i_regwriteM,
  input  logic [ADW-1:0] i_rdW,
  input  logic           i_regwriteW,
  output fwd_sel_t       o_sel
);

  logic w_hit_m;
  logic w_hit_w;

  assign w_hit_m = i_regwriteM && (i_rdM != '0)
                && (i_rdM == i_rs);
  assign w_hit_w = i_regwriteW && (i_rdW != '0)
                && (i_rdW == i_rs);

  always_comb begin
    o_sel = FWD_RF;
    priority case (1'b1)
      w_hit_m: o_sel = FWD_MEM;
      w_hit_w: o_sel = FWD_WB;
      default: o_sel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/hazard_controller.sv
// rv32i five-stage sequencing: load-use / branch / memory-wait
// control, operand forwarding and saturating stall/flush counters.
module hazard_controller
  import rv32i_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic [ADW-1:0]  rs1D,
  input  logic [ADW-1:0]  rs2D,
  input  logic [ADW-1:0]  rdD,
  input  logic            regwriteD,
  input  logic            resultsrcD,
  input  logic            memaccD,
  input  logic            pcsrcE,
  input  logic            dmem_ready,
  output logic            stallF,
  output logic            stallD,
  output logic            flushD,
  output logic            flushE,
  output logic            stallE,
  output logic            stallM,
  output logic            flushW,
  output fwd_sel_t        forwardAE,
  output fwd_sel_t        forwardBE,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  hz_state_t       r_state;
  hz_state_t       w_state_nxt;
  hz_e_t           r_e;
  hz_m_t           r_m;
  hz_w_t           r_w;
  logic [CNTW-1:0] r_stall_cnt;
  logic [CNTW-1:0] r_flush_cnt;
  logic            w_lduse;
  logic            w_memstall;
  logic            w_freeze;

  assign w_lduse = r_e.load && (r_e.rd != '0)
                && ((r_e.rd == rs1D) || (r_e.rd == rs2D));
  assign w_memstall = r_m.memacc && !dmem_ready;

  // The cycle that discovers the slow access already freezes,
  // otherwise the access would leave M before it completes.
  always_comb begin
    w_state_nxt = r_state;
    w_freeze    = 1'b0;
    stallF      = 1'b0;
    stallD      = 1'b0;
    flushD      = 1'b0;
    flushE      = 1'b0;
    unique case (r_state)
      HZ_RUN: begin
        if (w_memstall) begin
          w_state_nxt = HZ_MEM_WAIT;
          w_freeze    = 1'b1;
        end else if (pcsrcE) begin
          flushD = 1'b1;
          flushE = 1'b1;
        end else if (w_lduse) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end
      end
      HZ_MEM_WAIT: begin
        w_freeze = 1'b1;
        if (dmem_ready) w_state_nxt = HZ_RUN;
      end
      default: w_state_nxt = HZ_RUN;
    endcase
    if (w_freeze) begin
      stallF = 1'b1;
      stallD = 1'b1;
    end
  end

  assign stallE = w_freeze;
  assign stallM = w_freeze;
  assign flushW = w_freeze;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= HZ_RUN;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)     r_e <= '0;
    else if (flushE) r_e <= '0;
    else if (!stallE)
      r_e <= '{rs1: rs1D, rs2: rs2D, rd: rdD,
               regwrite: regwriteD, load: resultsrcD,
               memacc: memaccD};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_m <= '0;
    else if (!stallM)
      r_m <= '{rd: r_e.rd, regwrite: r_e.regwrite,
               memacc: r_e.memacc};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)     r_w <= '0;
    else if (flushW) r_w <= '0;
    else
      r_w <= '{rd: r_m.rd, regwrite: r_m.regwrite};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stallF && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNTW'(1);
      if (flushE && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNTW'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  forward_unit u_fwd_a (
    .i_rs        (r_e.rs1),
    .i_rdM       (r_m.rd),
    .i_regwriteM (r_m.regwrite),
    .i_rdW       (r_w.rd),
    .i_regwriteW (r_w.regwrite),
    .o_sel       (forwardAE)
  );

  forward_unit u_fwd_b (
    .i_rs        (r_e.rs2),
    .i_rdM       (r_m.rd),
    .i_regwriteM (r_m.regwrite),
    .i_rdW       (r_w.rd),
    .i_regwriteW (r_w.regwrite),
    .o_sel       (forwardBE)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: per-cycle vector table through a
// scoreboard queue, then saturation and mid-wait reset sequences.
module tb_hazard_controller;
  import rv32i_pkg::*;

  localparam int CNTW = 16;

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1101000;
  localparam logic [6:0] BR   = 7'b0011000;
  localparam logic [6:0] FRZ  = 7'b1100111;

  logic            clk;
  logic            arst_n;
  logic [ADW-1:0]  rs1D;
  logic [ADW-1:0]  rs2D;
  logic [ADW-1:0]  rdD;
  logic            regwriteD;
  logic            resultsrcD;
  logic            memaccD;
  logic            pcsrcE;
  logic            dmem_ready;
  logic            stallF;
  logic            stallD;
  logic            flushD;
  logic            flushE;
  logic            stallE;
  logic            stallM;
  logic            flushW;
  fwd_sel_t        forwardAE;
  fwd_sel_t        forwardBE;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;

  hazard_controller #(.CNTW(CNTW)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .rs1D       (rs1D),
    .rs2D       (rs2D),
    .rdD        (rdD),
    .regwriteD  (regwriteD),
    .resultsrcD (resultsrcD),
    .memaccD    (memaccD),
    .pcsrcE     (pcsrcE),
    .dmem_ready (dmem_ready),
    .stallF     (stallF),
    .stallD     (stallD),
    .flushD     (flushD),
    .flushE     (flushE),
    .stallE     (stallE),
    .stallM     (stallM),
    .flushW     (flushW),
    .forwardAE  (forwardAE),
    .forwardBE  (forwardBE),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADW-1:0] rs1;
    logic [ADW-1:0] rs2;
    logic [ADW-1:0] rd;
    logic           rw;
    logic           ld;
    logic           ma;
    logic           br;
    logic           rdy;
    logic [6:0]     ctl;
    logic [1:0]     fa;
    logic [1:0]     fb;
    int             sc;
    int             fc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic logic [6:0] ctl_now();
    return {stallF, stallD, flushD, flushE, stallE, stallM, flushW};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(int rs1, int rs2, int rd, bit rw, bit ld, bit ma,
                     bit br, bit rdy, logic [6:0] ctl, logic [1:0] fa,
                     logic [1:0] fb, int sc, int fc);
    vec_t v;
    v.rs1 = ADW'(rs1); v.rs2 = ADW'(rs2); v.rd = ADW'(rd);
    v.rw = rw; v.ld = ld; v.ma = ma; v.br = br; v.rdy = rdy;
    v.ctl = ctl; v.fa = fa; v.fb = fb; v.sc = sc; v.fc = fc;
    vecs.push_back(v);
  endtask

  task automatic drive_idle(bit rdy);
    rs1D = '0; rs2D = '0; rdD = '0;
    regwriteD = 1'b0; resultsrcD = 1'b0; memaccD = 1'b0;
    pcsrcE = 1'b0; dmem_ready = rdy;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " ctl"}, 32'(ctl_now()), 32'(NONE));
    chk({tag, " fwd"}, 32'({forwardAE, forwardBE}), 32'(0));
    chk({tag, " cnt"}, {stall_cnt, flush_cnt}, 32'(0));
  endtask

  initial begin
    vec_t e;
    arst_n = 1'b0;
    drive_idle(1'b1);
    #2;
    chk_zero("reset");
    #10 arst_n = 1'b1;

    //  rs1 rs2 rd rw ld ma br rdy  ctl  fa     fb     sc fc
    add(0, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 0, 0);
    add(1, 0, 5, 1, 1, 1, 0, 1, NONE, 2'b00, 2'b00, 0, 0);
    add(5, 2, 6, 1, 0, 0, 0, 1, LU,   2'b00, 2'b00, 0, 0);
    add(5, 2, 6, 1, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b01, 2'b00, 1, 1);
    add(0, 0, 3, 1, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 1);
    add(3, 3, 4, 1, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b10, 2'b10, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 1);
    add(0, 0, 7, 1, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 1);
    add(0, 0, 7, 1, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 1);
    add(7, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b10, 2'b00, 1, 1);
    add(0, 0, 7, 1, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 1);
    add(0, 0, 7, 0, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 1);
    add(7, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b01, 2'b00, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 1);
    add(0, 0, 5, 1, 1, 1, 0, 1, NONE, 2'b00, 2'b00, 1, 1);
    add(0, 5, 9, 1, 0, 0, 1, 1, BR,   2'b00, 2'b00, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 2);
    add(0, 0, 0, 0, 0, 0, 1, 1, BR,   2'b00, 2'b00, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 3);
    add(2, 3, 0, 0, 0, 1, 0, 1, NONE, 2'b00, 2'b00, 1, 3);
    add(1, 0, 11, 1, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 1, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, FRZ,  2'b00, 2'b00, 1, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, FRZ,  2'b00, 2'b00, 2, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, FRZ,  2'b00, 2'b00, 3, 3);
    add(0, 0, 0, 0, 0, 0, 0, 1, FRZ,  2'b00, 2'b00, 4, 3);
    add(0, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 5, 3);
    add(11, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b00, 2'b00, 5, 3);
    add(0, 0, 0, 0, 0, 0, 0, 1, NONE, 2'b01, 2'b00, 5, 3);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rs1D = vecs[i].rs1; rs2D = vecs[i].rs2; rdD = vecs[i].rd;
      regwriteD = vecs[i].rw; resultsrcD = vecs[i].ld;
      memaccD = vecs[i].ma; pcsrcE = vecs[i].br;
      dmem_ready = vecs[i].rdy;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("row%0d ctl", i), 32'(ctl_now()), 32'(e.ctl));
      chk($sformatf("row%0d fwd", i),
          32'({forwardAE, forwardBE}), 32'({e.fa, e.fb}));
      chk($sformatf("row%0d stall_cnt", i), 32'(stall_cnt), e.sc);
      chk($sformatf("row%0d flush_cnt", i), 32'(flush_cnt), e.fc);
    end

    @(posedge clk);
    #1 arst_n = 1'b0;
    drive_idle(1'b1);
    #1;
    chk_zero("clr");
    #2 arst_n = 1'b1;

    // Park a memory access in M with dmem_ready low to force stalls.
    @(posedge clk);
    #1;
    drive_idle(1'b0);
    memaccD = 1'b1;
    @(posedge clk);
    #1 drive_idle(1'b0);
    repeat ((1 << CNTW) + 5) @(posedge clk);
    @(negedge clk);
    chk("sat stall_cnt", 32'(stall_cnt), 32'hFFFF);
    chk("sat flush_cnt", 32'(flush_cnt), 32'(0));
    chk("sat ctl", 32'(ctl_now()), 32'(FRZ));
    chk("sat state", 32'(dut.r_state), 32'(HZ_MEM_WAIT));

    #2 arst_n = 1'b0;
    #1;
    chk_zero("midrst");
    chk("midrst state", 32'(dut.r_state), 32'(HZ_RUN));
    @(posedge clk);
    #2 arst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("postrst");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
